// File: rtl/fios_pkg.sv
// Shared sizing and FSM encoding for the FIOS j-loop sequencer.
// Defaults match the 448-bit Fp^2 datapath (14 x 32-bit words).
package fios_pkg;

   localparam int RADIX  = 32;
   localparam int NWORDS = 14;
   localparam int ADDR_W = 4;
   localparam int CW     = RADIX + 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

endpackage

// File: rtl/fios_j_loop_seq_step_add.sv
// Two-stage FIOS step: a0*a1 + b0*b1 + c0*c1 + d + carry_in, split into sum and carry.
// Products registered at k, d/carry_in added at k+1, sum/carry_out visible at k+2; no stall.
module step_add #(
   parameter int RADIX = 32,
   parameter int CW    = RADIX + 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic [RADIX-1:0] a0,
   input  logic [RADIX-1:0] a1,
   input  logic [RADIX-1:0] b0,
   input  logic [RADIX-1:0] b1,
   input  logic [RADIX-1:0] c0,
   input  logic [RADIX-1:0] c1,
   input  logic [RADIX-1:0] d,
   input  logic [CW-1:0]    carry_in,
   output logic             out_vld,
   output logic [RADIX-1:0] sum,
   output logic [CW-1:0]    carry_out
);
   // Three full products plus d and a CW-bit carry stay below 2^(2*RADIX+2).
   localparam int PW = 2 * RADIX + 2;

   logic          prod_vld;
   logic [PW-1:0] prod_q;
   logic [PW-1:0] acc;

   assign acc = prod_q + PW'(d) + PW'(carry_in);

   always_ff @(posedge clk) begin
      if (rst) begin
         prod_vld  <= 1'b0;
         prod_q    <= '0;
         out_vld   <= 1'b0;
         sum       <= '0;
         carry_out <= '0;
      end else begin
         prod_vld  <= in_vld;
         prod_q    <= PW'(a0) * PW'(a1) + PW'(b0) * PW'(b1) + PW'(c0) * PW'(c1);
         out_vld   <= prod_vld;
         sum       <= acc[RADIX-1:0];
         carry_out <= acc[PW-1:RADIX];
      end
   end

endmodule

// File: rtl/fios_j_loop_seq.sv
// One FIOS i-iteration: streams j=0..NWORDS-1 through step_add and writes t[j-1], then folds the carry.
// start to done is NWORDS+5 cycles at one word per cycle; start is ignored while busy, no backpressure.
module fios_j_loop_seq
   import fios_pkg::*;
#(
   parameter int RADIX  = fios_pkg::RADIX,
   parameter int NWORDS = fios_pkg::NWORDS,
   parameter int ADDR_W = fios_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              clear_top,
   input  logic [RADIX-1:0]  ob0_i,
   input  logic [RADIX-1:0]  ob1_i,
   input  logic [RADIX-1:0]  mm,
   output logic [ADDR_W-1:0] op_raddr,
   input  logic [RADIX-1:0]  oa0_rdata,
   input  logic [RADIX-1:0]  oa1_rdata,
   input  logic [RADIX-1:0]  m_rdata,
   output logic [ADDR_W-1:0] t_raddr,
   input  logic [RADIX-1:0]  t_rdata,
   output logic              t_wen,
   output logic [ADDR_W-1:0] t_waddr,
   output logic [RADIX-1:0]  t_wdata,
   output logic [1:0]        t_top,
   output logic              busy,
   output logic              done
);
   localparam int                CW   = RADIX + 2;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NWORDS - 1);

   state_t            state_q, state_d;
   logic [RADIX-1:0]  ob0_q, ob1_q, mm_q;
   logic [ADDR_W-1:0] j_q;
   logic              v1_q, v2_q;
   logic [ADDR_W-1:0] idx1_q, idx2_q, idx3_q;
   logic              sa_vld;
   logic [RADIX-1:0]  sa_sum;
   logic [CW-1:0]     sa_carry;
   logic [CW-1:0]     carry_in;
   logic              last_out;
   logic [CW:0]       fold;
   logic              fin_vld_q;
   logic [RADIX-1:0]  fin_s_q;
   logic              sum_wen;

   assign op_raddr = j_q;
   assign t_raddr  = idx1_q;
   assign carry_in = (idx2_q == '0) ? '0 : sa_carry;
   assign last_out = sa_vld && (idx3_q == LAST);
   assign fold     = {1'b0, sa_carry} + {{(CW - 1){1'b0}}, t_top};
   // Word 0's sum is zero by choice of mm, so it never reaches the t RAM.
   assign sum_wen  = sa_vld && (idx3_q != '0);

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (j_q == LAST) state_d = ST_FLUSH;
         ST_FLUSH: if (fin_vld_q) state_d = ST_FIN;
         ST_FIN:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         ST_RUN, ST_FLUSH: busy = 1'b1;
         ST_FIN:           done = 1'b1;
         default:          ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ob0_q     <= '0;
         ob1_q     <= '0;
         mm_q      <= '0;
         j_q       <= '0;
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         idx1_q    <= '0;
         idx2_q    <= '0;
         idx3_q    <= '0;
         fin_vld_q <= 1'b0;
         fin_s_q   <= '0;
         t_top     <= '0;
      end else begin
         if (state_q == ST_IDLE && start) begin
            ob0_q <= ob0_i;
            ob1_q <= ob1_i;
            mm_q  <= mm;
            j_q   <= '0;
            if (clear_top) t_top <= '0;
         end else if (state_q == ST_RUN) begin
            j_q <= j_q + 1'b1;
         end
         // Index rides alongside the RAM read latency and both step_add stages.
         v1_q      <= (state_q == ST_RUN);
         idx1_q    <= j_q;
         v2_q      <= v1_q;
         idx2_q    <= idx1_q;
         idx3_q    <= idx2_q;
         fin_vld_q <= last_out;
         if (last_out) begin
            fin_s_q <= fold[RADIX-1:0];
            t_top   <= fold[RADIX+1:RADIX];
         end
      end
   end

   step_add #(.RADIX(RADIX), .CW(CW)) u_step (
      .clk       (clk),
      .rst       (rst),
      .in_vld    (v1_q),
      .a0        (oa0_rdata),
      .a1        (ob0_q),
      .b0        (oa1_rdata),
      .b1        (ob1_q),
      .c0        (m_rdata),
      .c1        (mm_q),
      .d         (t_rdata),
      .carry_in  (carry_in),
      .out_vld   (sa_vld),
      .sum       (sa_sum),
      .carry_out (sa_carry)
   );

   always_comb begin
      t_wen   = 1'b0;
      t_waddr = '0;
      t_wdata = '0;
      if (fin_vld_q) begin
         t_wen   = 1'b1;
         t_waddr = LAST;
         t_wdata = fin_s_q;
      end else if (sum_wen) begin
         t_wen   = 1'b1;
         t_waddr = idx3_q - 1'b1;
         t_wdata = sa_sum;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(sum_wen && fin_vld_q)) else $error("two t writes in one cycle");
         if (last_out) assert (fold[CW] == 1'b0) else $error("t_top overflow");
      end
   end

endmodule

// File: tb/tb_fios_j_loop_seq.sv
// Scoreboard bench for fios_j_loop_seq with NWORDS=4 and 1-cycle RAM models.
// Expected t writes come from a wide-integer FIOS reference, popped as the DUT writes.
module tb_fios_j_loop_seq;
   localparam int RADIX  = 32;
   localparam int NWORDS = 4;
   localparam int ADDR_W = 4;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [RADIX-1:0]  data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              clear_top = 1'b0;
   logic [RADIX-1:0]  ob0_i = '0, ob1_i = '0, mm = '0;
   logic [ADDR_W-1:0] op_raddr, t_raddr, t_waddr;
   logic [RADIX-1:0]  oa0_rdata, oa1_rdata, m_rdata, t_rdata, t_wdata;
   logic              t_wen, busy, done;
   logic [1:0]        t_top;

   logic [RADIX-1:0]  oa0_mem [16];
   logic [RADIX-1:0]  oa1_mem [16];
   logic [RADIX-1:0]  m_mem   [16];
   logic [RADIX-1:0]  t_mem   [16];
   logic              pl_en = 1'b0;
   logic [ADDR_W-1:0] pl_addr = '0;
   logic [RADIX-1:0]  pl_dat = '0;

   logic [RADIX-1:0]  mdl_t [NWORDS];
   logic [1:0]        mdl_top = '0;
   wr_t               exp_q [$];
   wr_t               mon_e;
   bit                sb_en = 1'b1;
   int                checks = 0, errors = 0;
   int                cyc = 0, wr_cnt = 0, done_cnt = 0;

   fios_j_loop_seq #(.RADIX(RADIX), .NWORDS(NWORDS), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .clear_top(clear_top),
      .ob0_i(ob0_i), .ob1_i(ob1_i), .mm(mm),
      .op_raddr(op_raddr), .oa0_rdata(oa0_rdata), .oa1_rdata(oa1_rdata), .m_rdata(m_rdata),
      .t_raddr(t_raddr), .t_rdata(t_rdata), .t_wen(t_wen), .t_waddr(t_waddr), .t_wdata(t_wdata),
      .t_top(t_top), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc       <= cyc + 1;
      oa0_rdata <= oa0_mem[op_raddr];
      oa1_rdata <= oa1_mem[op_raddr];
      m_rdata   <= m_mem[op_raddr];
      t_rdata   <= t_mem[t_raddr];
      if (t_wen)      t_mem[t_waddr] <= t_wdata;
      else if (pl_en) t_mem[pl_addr] <= pl_dat;
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (t_wen) begin
         wr_cnt++;
         if (sb_en) begin
            if (exp_q.size() == 0) begin
               check_eq("sb_unexpected_wr", 64'(t_waddr), 64'hFFFF);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("wr_addr", 64'(t_waddr), 64'(mon_e.addr));
               check_eq("wr_data", 64'(t_wdata), 64'(mon_e.data));
            end
         end
      end
   end

   // mode 0: zeros, 1: all ones, 2: random
   function automatic logic [RADIX-1:0] pick(input int mode);
      if (mode == 0) return '0;
      if (mode == 1) return '1;
      return $urandom;
   endfunction

   task automatic set_ops(input int mode);
      for (int j = 0; j < NWORDS; j++) begin
         oa0_mem[j] = pick(mode);
         oa1_mem[j] = pick(mode);
         m_mem[j]   = pick(mode);
      end
   endtask

   task automatic load_t(input int mode);
      for (int j = 0; j < NWORDS; j++) begin
         @(negedge clk);
         pl_en    = 1'b1;
         pl_addr  = ADDR_W'(j);
         pl_dat   = pick(mode);
         mdl_t[j] = pl_dat;
      end
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic run_iter(input bit clr, input logic [RADIX-1:0] b0, input logic [RADIX-1:0] b1,
                           input logic [RADIX-1:0] mmv, input int poke);
      logic [191:0] acc, res;
      wr_t e;
      int  s, wr0, dn0;
      bit  seen;
      if (clr) mdl_top = '0;
      acc = 192'(mdl_top) << (RADIX * NWORDS);
      for (int j = 0; j < NWORDS; j++) begin
         acc += 192'(mdl_t[j]) << (RADIX * j);
         acc += (192'(oa0_mem[j]) * 192'(b0) + 192'(oa1_mem[j]) * 192'(b1)
                 + 192'(m_mem[j]) * 192'(mmv)) << (RADIX * j);
      end
      res = acc >> RADIX;
      for (int j = 0; j < NWORDS; j++) begin
         mdl_t[j] = res[RADIX*j +: RADIX];
         e.addr   = ADDR_W'(j);
         e.data   = mdl_t[j];
         exp_q.push_back(e);
      end
      mdl_top = res[RADIX*NWORDS +: 2];

      @(negedge clk);
      start = 1'b1; clear_top = clr; ob0_i = b0; ob1_i = b1; mm = mmv;
      s = cyc; wr0 = wr_cnt; dn0 = done_cnt; seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         start     = (poke != 0 && k == poke);
         clear_top = 1'b0;
         ob0_i = $urandom; ob1_i = $urandom; mm = $urandom;
         if (k == 1) check_eq("busy_after_start", 64'(busy), 64'd1);
         if (done) begin
            seen = 1'b1;
            check_eq("done_latency", 64'(cyc - s), 64'(NWORDS + 5));
            check_eq("busy_at_done", 64'(busy), 64'd0);
            check_eq("t_top", 64'(t_top), 64'(mdl_top));
         end
      end
      start = 1'b0;
      if (!seen) check_eq("done_timeout", 64'd0, 64'd1);
      check_eq("wr_count", 64'(wr_cnt - wr0), 64'(NWORDS));
      check_eq("sb_left", 64'(exp_q.size()), 64'd0);
      if (poke != 0) begin
         @(negedge clk);
         @(negedge clk);
         check_eq("done_pulses", 64'(done_cnt - dn0), 64'd1);
      end
   endtask

   initial begin
      int s, post_wr, post_done;
      for (int i = 0; i < 16; i++) begin
         oa0_mem[i] = '0; oa1_mem[i] = '0; m_mem[i] = '0; t_mem[i] = '0;
      end
      repeat (3) @(negedge clk);
      check_eq("rst_op_raddr", 64'(op_raddr), 64'd0);
      check_eq("rst_t_wen", 64'(t_wen), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_t_top", 64'(t_top), 64'd0);
      rst = 1'b0;

      // zeros
      set_ops(0);
      load_t(0);
      run_iter(1'b1, '0, '0, '0, 0);

      // max carry chain, leaves t_top = 2 for the fold case
      set_ops(1);
      load_t(1);
      run_iter(1'b1, '1, '1, '1, 0);
      @(negedge clk);
      check_eq("top_before_fold", 64'(t_top), 64'd2);

      // fold of a preloaded t_top
      set_ops(2);
      run_iter(1'b0, $urandom, $urandom, $urandom, 0);

      // back-to-back iterations
      set_ops(2);
      load_t(2);
      for (int it = 0; it < 4; it++) begin
         set_ops(2);
         run_iter(it == 0, $urandom, $urandom, $urandom, 0);
      end

      // start pulsed while busy
      set_ops(2);
      run_iter(1'b0, $urandom, $urandom, $urandom, 3);

      // reset mid-iteration
      set_ops(2);
      load_t(2);
      sb_en = 1'b0;
      @(negedge clk);
      start = 1'b1; clear_top = 1'b0; ob0_i = $urandom; ob1_i = $urandom; mm = $urandom;
      s = cyc; post_wr = 0; post_done = 0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k >= 6) begin
            if (t_wen) post_wr++;
            if (done) post_done++;
         end
         if (k == 6) begin
            check_eq("rst_mid_busy", 64'(busy), 64'd0);
            check_eq("rst_mid_t_top", 64'(t_top), 64'd0);
         end
         rst = (k == 5);
      end
      check_eq("rst_mid_writes", 64'(post_wr), 64'd0);
      check_eq("rst_mid_done", 64'(post_done), 64'd0);
      check_eq("rst_mid_cycles", 64'(cyc - s), 64'd14);
      sb_en = 1'b1;
      mdl_top = '0;
      load_t(2);
      run_iter(1'b0, $urandom, $urandom, $urandom, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
